// File: rtl/vproc_lat_mem.sv
`default_nettype none
// ============================================================================
// Module   : vproc_lat_mem
// Purpose  : Multi-port, byte-addressed behavioural memory for vproc
//            simulation benches. Every port has a req/gnt/rvalid handshake
//            and its own response pipeline of LATENCY stages. Out-of-range
//            accesses return an error response. A port-0 request to address
//            0 raises a one-cycle end-of-program pulse.
// Config   : VPROC_MEM_STALL_EN - when defined, each port grants through a
//            free-running 16-bit LFSR so requesters see random stalls;
//            when undefined, every request is granted combinationally.
// Ports    : clk_i       clock
//            rst_ni      synchronous active-low reset
//            req_i       per-port request
//            addr_i      per-port byte address (32 bits each)
//            we_i        per-port write enable
//            be_i        per-port byte enables (MEM_W/8 bits each)
//            wdata_i     per-port write data (MEM_W bits each)
//            gnt_o       per-port grant; accepted when req_i & gnt_o
//            rvalid_o    per-port response valid (reads and writes)
//            err_o       per-port error, qualified by rvalid_o
//            rdata_o     per-port read data, qualified by rvalid_o
//            prog_end_o  pulse: port 0 accepted a request to address 0
// Revision : 1.0 - initial release
// ============================================================================
module vproc_lat_mem #(
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned MEM_W   = 32,
  parameter int unsigned MEM_SZ  = 262144,
  parameter int unsigned LATENCY = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NPORTS-1:0]          req_i,
  input  logic [NPORTS*32-1:0]       addr_i,
  input  logic [NPORTS-1:0]          we_i,
  input  logic [NPORTS*MEM_W/8-1:0]  be_i,
  input  logic [NPORTS*MEM_W-1:0]    wdata_i,
  output logic [NPORTS-1:0]          gnt_o,
  output logic [NPORTS-1:0]          rvalid_o,
  output logic [NPORTS-1:0]          err_o,
  output logic [NPORTS*MEM_W-1:0]    rdata_o,
  output logic                       prog_end_o
);

  localparam int unsigned BYTES = MEM_W / 8;
  localparam int unsigned AW    = $clog2(MEM_SZ);
  localparam int unsigned OFF   = $clog2(BYTES);
  localparam int unsigned WORDS = MEM_SZ / BYTES;
  localparam int unsigned IW    = AW - OFF;

  // Storage; preloaded by benches through hierarchical access and never
  // cleared by reset.
  logic [MEM_W-1:0] mem [WORDS];

  logic [NPORTS-1:0]           accept;
  logic [NPORTS-1:0]           addr_err;
  logic [NPORTS-1:0][IW-1:0]   word_idx;
  logic [NPORTS-1:0][MEM_W-1:0] rd_word;

  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic [31:0] addr;
      logic        unused_addr_lo;

      assign addr           = addr_i[p*32 +: 32];
      assign word_idx[p]    = addr[AW-1:OFF];
      assign addr_err[p]    = |addr[31:AW];
      assign accept[p]      = req_i[p] & gnt_o[p];
      // Combinational read of the current contents: sampled at the
      // accepting edge this yields the pre-write (read-old) word.
      assign rd_word[p]     = mem[word_idx[p]];
      // Sub-word offset bits do not select storage.
      assign unused_addr_lo = ^addr[OFF-1:0];

`ifdef VPROC_MEM_STALL_EN
      // Fibonacci LFSR, taps 16,14,13,11, advanced every cycle.
      logic [15:0] lfsr;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          lfsr <= 16'hACE1 ^ 16'(p);
        end else begin
          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
      end
      assign gnt_o[p] = req_i[p] & lfsr[0];
`else
      assign gnt_o[p] = req_i[p];
`endif

      // Response pipeline: stage 0 is loaded at the accepting edge, the
      // last stage drives the port outputs. Data only moves along with a
      // valid token so rdata_o keeps its last value while idle.
      logic [LATENCY-1:0]            vld;
      logic [LATENCY-1:0]            ers;
      logic [LATENCY-1:0][MEM_W-1:0] dat;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld <= '0;
          ers <= '0;
          dat <= '0;
        end else begin
          vld[0] <= accept[p];
          if (accept[p]) begin
            ers[0] <= addr_err[p];
            dat[0] <= addr_err[p] ? '0 : rd_word[p];
          end
          for (int s = 1; s < LATENCY; s++) begin
            vld[s] <= vld[s-1];
            if (vld[s-1]) begin
              ers[s] <= ers[s-1];
              dat[s] <= dat[s-1];
            end
          end
        end
      end

      assign rvalid_o[p]               = vld[LATENCY-1];
      assign err_o[p]                  = vld[LATENCY-1] & ers[LATENCY-1];
      assign rdata_o[p*MEM_W +: MEM_W] = dat[LATENCY-1];
    end
  endgenerate

  // Writes: ports are applied from highest to lowest index so that, on
  // overlapping bytes of the same word, the lowest port's value lands last.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int p = NPORTS - 1; p >= 0; p--) begin
        if (accept[p] && we_i[p] && !addr_err[p]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (be_i[p*BYTES + b]) begin
              mem[word_idx[p]][b*8 +: 8] <= wdata_i[p*MEM_W + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prog_end_o <= 1'b0;
    end else begin
      prog_end_o <= accept[0] & (addr_i[31:0] == 32'h0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vproc_lat_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_vproc_lat_mem
// Purpose  : Self-checking bench for vproc_lat_mem (2 ports, 32-bit words,
//            256 KiB, LATENCY=3). A word-level reference memory and per-port
//            queues of expected responses (due cycle, error, data) are
//            checked every cycle. Works with or without VPROC_MEM_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vproc_lat_mem;
  localparam int NP  = 2;
  localparam int MW  = 32;
  localparam int MSZ = 262144;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, we, gnt, rvalid, err;
  logic [63:0]   addr, wdata, rdata;
  logic [7:0]    be;
  logic          prog_end;

  always #5 clk = ~clk;

  vproc_lat_mem #(.NPORTS(NP), .MEM_W(MW), .MEM_SZ(MSZ), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .err_o(err),
    .rdata_o(rdata), .prog_end_o(prog_end)
  );

  typedef struct { bit v; logic [31:0] a; bit w; logic [3:0] be; logic [31:0] d; } req_t;
  typedef struct { int due; bit e; bit known; logic [31:0] d; } rsp_t;

  req_t        pend [2];
  rsp_t        expq [2][$];
  logic [31:0] mdl [int];      // reference memory, word index -> contents
  int          cyc, tests, fails, pe_count;
  logic [31:0] last_d [2];
  bit          last_e [2];

  // One clock cycle: drive pending requests, model accepted ones, then check
  // every output against the reference at the following negedge.
  task automatic step(input bit rst_val);
    bit          acc [2];
    bit          pe_exp;
    rsp_t        r;
    logic [31:0] cur;
    int          wi;
    rst_n = rst_val;
    for (int p = 0; p < 2; p++) begin
      req[p]            = pend[p].v;
      addr[p*32 +: 32]  = pend[p].a;
      we[p]             = pend[p].w;
      be[p*4 +: 4]      = pend[p].be;
      wdata[p*32 +: 32] = pend[p].d;
    end
    #1;
`ifdef VPROC_MEM_STALL_EN
    tests++;
    if ((gnt & ~req) !== 2'b00) begin
      fails++; $display("FAIL gnt_without_req: gnt=%b req=%b", gnt, req);
    end
`else
    tests++;
    if (gnt !== req) begin
      fails++; $display("FAIL gnt_comb: gnt=%b required=%b", gnt, req);
    end
`endif
    pe_exp = 1'b0;
    for (int p = 0; p < 2; p++) acc[p] = rst_val && pend[p].v && (gnt[p] === 1'b1);
    // All reads see the memory as it was before this edge's writes.
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        r.due = cyc + LAT;
        r.e   = (pend[p].a >= 32'(MSZ));
        if (r.e) begin
          r.d = 32'h0;
        end else begin
          wi  = int'(pend[p].a[17:2]);
          r.d = mdl.exists(wi) ? mdl[wi] : 32'hxxxx_xxxx;
        end
        r.known = !$isunknown(r.d);
        expq[p].push_back(r);
        if (p == 0 && pend[0].a == 32'h0) pe_exp = 1'b1;
      end
    end
    // Lowest port applied last: it owns overlapping bytes.
    for (int p = 1; p >= 0; p--) begin
      if (acc[p] && pend[p].w && (pend[p].a < 32'(MSZ))) begin
        wi  = int'(pend[p].a[17:2]);
        cur = mdl.exists(wi) ? mdl[wi] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (pend[p].be[b]) cur[b*8 +: 8] = pend[p].d[b*8 +: 8];
        mdl[wi] = cur;
      end
    end
    @(posedge clk);
    cyc++;
    for (int p = 0; p < 2; p++) if (acc[p]) pend[p].v = 1'b0;
    if (!rst_val) begin
      expq[0].delete();
      expq[1].delete();
    end
    @(negedge clk);
    tests++;
    if (prog_end !== pe_exp) begin
      fails++; $display("FAIL prog_end cyc=%0d: got %b required %b", cyc, prog_end, pe_exp);
    end
    if (prog_end === 1'b1) pe_count++;
    for (int p = 0; p < 2; p++) begin
      bit exp_v;
      exp_v = (expq[p].size() > 0) && (expq[p][0].due == cyc);
      tests++;
      if (rvalid[p] !== exp_v) begin
        fails++; $display("FAIL rvalid%0d cyc=%0d: got %b required %b", p, cyc, rvalid[p], exp_v);
      end
      if (rvalid[p] === 1'b1 && expq[p].size() > 0) begin
        r = expq[p].pop_front();
        last_d[p] = rdata[p*32 +: 32];
        last_e[p] = err[p];
        tests++;
        if (err[p] !== r.e) begin
          fails++; $display("FAIL err%0d cyc=%0d: got %b required %b", p, cyc, err[p], r.e);
        end
        if (r.known) begin
          tests++;
          if (rdata[p*32 +: 32] !== r.d) begin
            fails++; $display("FAIL rdata%0d cyc=%0d: got %h required %h", p, cyc, rdata[p*32 +: 32], r.d);
          end
        end
      end
      while (expq[p].size() > 0 && expq[p][0].due < cyc) void'(expq[p].pop_front());
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend[0].v || pend[1].v) && n < 300) begin step(1'b1); n++; end
    tests++;
    if (pend[0].v || pend[1].v) begin
      fails++; $display("FAIL grant_timeout: pending=%b%b required 00", pend[1].v, pend[0].v);
      pend[0].v = 1'b0; pend[1].v = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq[0].size() > 0 || expq[1].size() > 0) && n < 50) begin step(1'b1); n++; end
    tests++;
    if (expq[0].size() > 0 || expq[1].size() > 0) begin
      fails++; $display("FAIL response_timeout: outstanding=%0d required 0", expq[0].size() + expq[1].size());
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input bit w,
                       input logic [3:0] b, input logic [31:0] d);
    pend[p] = '{v: 1'b1, a: a, w: w, be: b, d: d};
    wait_idle();
  endtask

  task automatic expect_last(input string nm, input int p, input logic [31:0] d, input bit e);
    tests++;
    if (last_d[p] !== d || last_e[p] !== e) begin
      fails++; $display("FAIL %s: got data=%h err=%b required data=%h err=%b", nm, last_d[p], last_e[p], d, e);
    end
  endtask

  task automatic test_reset();
    pend[0].v = 1'b0; pend[1].v = 1'b0;
    step(1'b0);
    step(1'b0);
    tests++;
    if (rvalid !== 2'b00 || err !== 2'b00 || rdata !== 64'h0 || prog_end !== 1'b0) begin
      fails++; $display("FAIL reset_state: got rvalid=%b err=%b rdata=%h pe=%b required all 0", rvalid, err, rdata, prog_end);
    end
    step(1'b1);
  endtask

  task automatic test_write_read();
    issue(0, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
    issue(0, 32'h100, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("read_after_write", 0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_partial();
    issue(0, 32'h200, 1'b1, 4'hF, 32'h11223344);
    issue(0, 32'h201, 1'b1, 4'b0010, 32'h0000AA00);
    issue(0, 32'h200, 1'b0, 4'h0, 32'h0);
    drain();
    expect_last("partial_write", 0, 32'h1122AA44, 1'b0);
    issue(0, 32'h100, 1'b1, 4'h0, 32'hFFFFFFFF);   // no enables: answered, no change
    drain();
    expect_last("write_be0_resp", 0, last_d[0], 1'b0);
    issue(0, 32'h100, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("write_be0_unchanged", 0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_out_of_range();
    issue(1, 32'h0004_0000, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("oor_read", 1, 32'h0, 1'b1);
    issue(1, 32'h0004_0100, 1'b1, 4'hF, 32'hBADBAD00);  // aliases 0x100 if not blocked
    drain();
    expect_last("oor_write", 1, 32'h0, 1'b1);
    issue(1, 32'h100, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("oor_write_no_effect", 1, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_same_word();
    issue(0, 32'h300, 1'b1, 4'hF, 32'h0);
    pend[0] = '{v: 1'b1, a: 32'h300, w: 1'b1, be: 4'b0001, d: 32'h000000FF};
    pend[1] = '{v: 1'b1, a: 32'h300, w: 1'b1, be: 4'b0011, d: 32'h0000FFFF};
    wait_idle();
    issue(1, 32'h300, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("same_word_merge", 1, 32'h0000FFFF, 1'b0);
    // Overlapping full-word writes plus concurrent reads; the model decides.
    pend[0] = '{v: 1'b1, a: 32'h304, w: 1'b1, be: 4'hF, d: 32'h11111111};
    pend[1] = '{v: 1'b1, a: 32'h304, w: 1'b1, be: 4'hF, d: 32'h22222222};
    wait_idle();
    pend[0] = '{v: 1'b1, a: 32'h304, w: 1'b1, be: 4'hF, d: 32'h33333333};
    pend[1] = '{v: 1'b1, a: 32'h304, w: 1'b0, be: 4'hF, d: 32'h0};
    wait_idle();
    issue(1, 32'h304, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("write_then_read", 1, 32'h33333333, 1'b0);
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 8; i++) begin
      if (!pend[0].v) pend[0] = '{v: 1'b1, a: 32'h100, w: 1'b0, be: 4'hF, d: 32'h0};
      if (!pend[1].v) pend[1] = '{v: 1'b1, a: 32'h200, w: 1'b0, be: 4'hF, d: 32'h0};
      step(1'b1);
    end
    pend[0].v = 1'b0; pend[1].v = 1'b0;
    step(1'b0);
    tests++;
    if (rvalid !== 2'b00) begin
      fails++; $display("FAIL flush_rvalid: got %b required 00", rvalid);
    end
    for (int i = 0; i < LAT + 3; i++) step(1'b1);
    issue(0, 32'h200, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("storage_kept_200", 0, 32'h1122AA44, 1'b0);
    issue(1, 32'h300, 1'b0, 4'hF, 32'h0);
    drain();
    expect_last("storage_kept_300", 1, 32'h0000FFFF, 1'b0);
  endtask

  task automatic test_prog_end();
    pe_count = 0;
    issue(1, 32'h0, 1'b0, 4'hF, 32'h0);   // port 1 must not flag
    issue(0, 32'h4, 1'b0, 4'hF, 32'h0);   // non-zero address must not flag
    issue(0, 32'h0, 1'b0, 4'hF, 32'h0);
    drain();
    step(1'b1);
    tests++;
    if (pe_count !== 1) begin
      fails++; $display("FAIL prog_end_count: got %0d required 1", pe_count);
    end
  endtask

  task automatic test_random();
    int issued = 0;
    int n = 0;
    int sel;
    for (int i = 0; i < 64; i++) issue(0, 32'h800 + 32'(i * 4), 1'b1, 4'hF, $urandom);
    while (issued < 100 && n < 5000) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].v && issued < 100 && $urandom_range(0, 3) != 0) begin
          sel = $urandom_range(0, 9);
          pend[p].v  = 1'b1;
          pend[p].a  = (sel == 0) ? ($urandom | 32'h0004_0000)
                                  : 32'h800 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
          pend[p].w  = 1'($urandom_range(0, 1));
          pend[p].be = 4'($urandom);
          pend[p].d  = $urandom;
          issued++;
        end
      end
      step(1'b1);
      n++;
    end
    wait_idle();
    drain();
    tests++;
    if (issued != 100) begin
      fails++; $display("FAIL random_issue_count: got %0d required 100", issued);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; addr = '0; we = '0; be = '0; wdata = '0;
    cyc = 0; tests = 0; fails = 0; pe_count = 0;
    pend[0] = '{v: 1'b0, a: 32'h0, w: 1'b0, be: 4'h0, d: 32'h0};
    pend[1] = pend[0];
    @(negedge clk);
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_same_word();
    test_reset_flush();
    test_prog_end();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
